// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: instruction fields, opcode,
// carry-in and condition encodings, FSM state codes and the condition evaluator.
package alu_pkg;

  localparam logic [1:0] CODE_ARM = 2'b11;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MOV  = 3'b010,
    OP_XSR  = 3'b011,
    OP_MUL  = 3'b100,
    OP_RSV5 = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    CIN_ZERO  = 2'b00,
    CIN_ONE   = 2'b01,
    CIN_CARRY = 2'b10,
    CIN_RSMSB = 2'b11
  } cin_e;

  localparam logic [3:0] COND_NEVER  = 4'b0000;
  localparam logic [3:0] COND_ALWAYS = 4'b0001;
  localparam logic [3:0] COND_ZERO   = 4'b0010;
  localparam logic [3:0] COND_NZERO  = 4'b0011;
  localparam logic [3:0] COND_CARRY  = 4'b0100;
  localparam logic [3:0] COND_NCARRY = 4'b0101;
  localparam logic [3:0] COND_NEG    = 4'b0110;
  localparam logic [3:0] COND_NNEG   = 4'b0111;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_MULRUN = 1'b1;

  // Bit layout of the 16-bit instruction word, MSB first.
  typedef struct packed {
    logic [1:0] code;
    cin_e       cin;
    logic [3:0] cond;
    logic       cw;
    op_e        op;
    logic [3:0] rsvd;
  } instr_t;

  function automatic logic cond_true(input logic [3:0] cond, input logic r_zero,
                                     input logic r_msb, input logic c);
    logic hit;
    case (cond)
      COND_ALWAYS: hit = 1'b1;
      COND_ZERO:   hit = r_zero;
      COND_NZERO:  hit = !r_zero;
      COND_CARRY:  hit = c;
      COND_NCARRY: hit = !c;
      COND_NEG:    hit = r_msb;
      COND_NNEG:   hit = !r_msb;
      default:     hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between an instruction issuer and the sequential ALU.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic [15:0]      instruction;
  logic             start;
  logic [WIDTH-1:0] rddata;
  logic [WIDTH-1:0] rsdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] aluout;
  logic             wenout;
  logic             carrystatus;
  logic             skipstatus;

  modport master (
    output instruction, start, rddata, rsdata,
    input  busy, done, aluout, wenout, carrystatus, skipstatus
  );

  modport slave (
    input  instruction, start, rddata, rsdata,
    output busy, done, aluout, wenout, carrystatus, skipstatus
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: load performs the first partial product,
// each step adds one more, finished rises once WIDTH partial products are in.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 finished
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   first_pp;

  genvar gi;
  generate
    for (gi = 0; gi < 2 * WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
    for (gi = 0; gi < WIDTH; gi++) begin : g_first_pp
      assign first_pp[gi] = mcand[gi] & mplier[0];
    end
  endgenerate

  always_comb begin
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    count_next  = count_reg;
    if (load) begin
      acc_next    = {{WIDTH{1'b0}}, first_pp};
      mcand_next  = {{(WIDTH - 1){1'b0}}, mcand, 1'b0};
      mplier_next = {1'b0, mplier[WIDTH-1:1]};
      count_next  = CNT_W'(1);
    end else if (step) begin
      acc_next    = acc_reg + addend;
      mcand_next  = {mcand_reg[2*WIDTH-2:0], 1'b0};
      mplier_next = {1'b0, mplier_reg[WIDTH-1:1]};
      count_next  = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      count_reg  <= count_next;
    end
  end

  assign product  = acc_reg;
  assign finished = (count_reg == CNT_W'(WIDTH));

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/mov/shift plus an iterative multiply,
// with a carry flag and a skip flag that squashes the next accepted instruction.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  alu_seq_if.slave     bus
);

  logic             state_reg, state_next;
  logic             done_reg, done_next;
  logic             wen_reg, wen_next;
  logic [WIDTH-1:0] aluout_reg, aluout_next;
  logic             carry_reg, carry_next;
  logic             skip_reg, skip_next;
  logic [3:0]       cond_reg, cond_next;
  logic             cw_reg, cw_next;

  instr_t             dec;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               mul_load;
  logic               mul_step;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_finished;
  logic [WIDTH-1:0]   mul_lo;
  logic               mul_c;
  logic               unused_rsvd;

  assign dec         = instr_t'(bus.instruction);
  assign unused_rsvd = ^dec.rsvd;

  always_comb begin
    case (dec.cin)
      CIN_ZERO:  cin = 1'b0;
      CIN_ONE:   cin = 1'b1;
      CIN_CARRY: cin = carry_reg;
      default:   cin = bus.rsdata[WIDTH-1];
    endcase
  end

  // Single-cycle datapath; MUL and reserved opcodes fall through to zero.
  always_comb begin
    sum   = '0;
    res   = '0;
    res_c = 1'b0;
    case (dec.op)
      OP_ADD: begin
        sum = {1'b0, bus.rddata} + {1'b0, bus.rsdata} + {{WIDTH{1'b0}}, cin};
        {res_c, res} = sum;
      end
      OP_SUB: begin
        sum = {1'b0, bus.rddata} + {1'b0, ~bus.rsdata} + {{WIDTH{1'b0}}, cin};
        {res_c, res} = sum;
      end
      OP_MOV: begin
        sum = {1'b0, bus.rsdata} + {{WIDTH{1'b0}}, cin};
        {res_c, res} = sum;
      end
      OP_XSR: begin
        res   = {cin, bus.rsdata[WIDTH-1:1]};
        res_c = bus.rsdata[0];
      end
      default: begin
        res   = '0;
        res_c = 1'b0;
      end
    endcase
  end

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (mul_load),
    .step     (mul_step),
    .mcand    (bus.rddata),
    .mplier   (bus.rsdata),
    .product  (mul_product),
    .finished (mul_finished)
  );

  assign mul_lo = mul_product[WIDTH-1:0];
  assign mul_c  = |mul_product[2*WIDTH-1:WIDTH];

  always_comb begin
    state_next  = state_reg;
    done_next   = 1'b0;
    wen_next    = 1'b0;
    aluout_next = aluout_reg;
    carry_next  = carry_reg;
    skip_next   = skip_reg;
    cond_next   = cond_reg;
    cw_next     = cw_reg;
    mul_load    = 1'b0;
    mul_step    = 1'b0;
    if (state_reg == ST_MULRUN) begin
      // Incoming starts are dropped here; only the multiply advances.
      if (mul_finished) begin
        state_next  = ST_IDLE;
        done_next   = 1'b1;
        wen_next    = 1'b1;
        aluout_next = mul_lo;
        if (cw_reg) begin
          carry_next = mul_c;
        end
        skip_next = cond_true(cond_reg, mul_lo == '0, mul_lo[WIDTH-1], mul_c);
      end else begin
        mul_step = 1'b1;
      end
    end else if (bus.start) begin
      done_next = 1'b1;
      if (skip_reg) begin
        skip_next = 1'b0;
      end else if (dec.code == CODE_ARM) begin
        if (dec.op == OP_MUL) begin
          done_next  = 1'b0;
          state_next = ST_MULRUN;
          mul_load   = 1'b1;
          cond_next  = dec.cond;
          cw_next    = dec.cw;
        end else begin
          wen_next    = 1'b1;
          aluout_next = res;
          if (dec.cw) begin
            carry_next = res_c;
          end
          skip_next = cond_true(dec.cond, res == '0, res[WIDTH-1], res_c);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      done_reg   <= 1'b0;
      wen_reg    <= 1'b0;
      aluout_reg <= '0;
      carry_reg  <= 1'b0;
      skip_reg   <= 1'b0;
      cond_reg   <= COND_NEVER;
      cw_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      done_reg   <= done_next;
      wen_reg    <= wen_next;
      aluout_reg <= aluout_next;
      carry_reg  <= carry_next;
      skip_reg   <= skip_next;
      cond_reg   <= cond_next;
      cw_reg     <= cw_next;
    end
  end

  assign bus.busy        = (state_reg == ST_MULRUN);
  assign bus.done        = done_reg;
  assign bus.wenout      = wen_reg;
  assign bus.aluout      = aluout_reg;
  assign bus.carrystatus = carry_reg;
  assign bus.skipstatus  = skip_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a vector table of single-cycle operations,
// then hand-written multiply, squash and reset-abort sequences.
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] rd;
    logic [15:0] rs;
    logic [15:0] out;
    logic        wen;
    logic        carry;
    logic        skip;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] cin,
                                     input logic [3:0] cond, input logic cw);
    return {2'b11, cin, cond, cw, op, 4'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [15:0] instr, input logic [15:0] rd, input logic [15:0] rs);
    @(negedge clk);
    bus.instruction = instr;
    bus.rddata      = rd;
    bus.rsdata      = rs;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [15:0] out, input logic wen,
                            input logic carry, input logic skip);
    check({tag, ".done"}, 32'(bus.done), 32'(1'b1));
    check({tag, ".busy"}, 32'(bus.busy), 32'(1'b0));
    check({tag, ".aluout"}, 32'(bus.aluout), 32'(out));
    check({tag, ".wenout"}, 32'(bus.wenout), 32'(wen));
    check({tag, ".carry"}, 32'(bus.carrystatus), 32'(carry));
    check({tag, ".skip"}, 32'(bus.skipstatus), 32'(skip));
    $display("%s: out=%h wen=%b carry=%b skip=%b", tag, bus.aluout, bus.wenout,
             bus.carrystatus, bus.skipstatus);
  endtask

  // Waits for done from cycle T+1 onward; returns latency counted from T.
  task automatic wait_done(output int lat, output int busy_gaps);
    lat = 1;
    busy_gaps = 0;
    while (!bus.done && lat < 40) begin
      if (!bus.busy) busy_gaps++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int gaps;

    vecs[0]  = '{mk(3'b000, 2'b00, 4'b0010, 1'b1), 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{mk(3'b010, 2'b00, 4'b0000, 1'b0), 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{mk(3'b011, 2'b11, 4'b0000, 1'b1), 16'h0000, 16'h0003, 16'h0001, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{mk(3'b011, 2'b11, 4'b0000, 1'b1), 16'h0000, 16'h8002, 16'hC001, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{mk(3'b001, 2'b01, 4'b0100, 1'b1), 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{mk(3'b000, 2'b00, 4'b0000, 1'b1), 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{mk(3'b000, 2'b10, 4'b0110, 1'b0), 16'h7FFF, 16'h0000, 16'h8000, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{mk(3'b010, 2'b00, 4'b0000, 1'b1), 16'h0000, 16'h5555, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{mk(3'b001, 2'b01, 4'b0101, 1'b1), 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{mk(3'b101, 2'b00, 4'b0000, 1'b1), 16'h1111, 16'h2222, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{mk(3'b110, 2'b00, 4'b0010, 1'b1), 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{mk(3'b011, 2'b01, 4'b0000, 1'b1), 16'h0000, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{mk(3'b010, 2'b01, 4'b0011, 1'b1), 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{16'h4000,                         16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{mk(3'b000, 2'b00, 4'b0001, 1'b0), 16'h1234, 16'h1111, 16'h2345, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{mk(3'b010, 2'b00, 4'b0000, 1'b0), 16'h0000, 16'h0001, 16'h2345, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{mk(3'b000, 2'b00, 4'b1000, 1'b1), 16'h0001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{mk(3'b000, 2'b11, 4'b0111, 1'b1), 16'h0000, 16'h00FF, 16'h00FF, 1'b1, 1'b0, 1'b1};

    bus.instruction = 16'h0000;
    bus.rddata      = 16'h0000;
    bus.rsdata      = 16'h0000;
    bus.start       = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(bus.busy), 32'(1'b0));
    check("rst.done", 32'(bus.done), 32'(1'b0));
    check("rst.wenout", 32'(bus.wenout), 32'(1'b0));
    check("rst.aluout", 32'(bus.aluout), 32'h0);
    check("rst.carry", 32'(bus.carrystatus), 32'(1'b0));
    check("rst.skip", 32'(bus.skipstatus), 32'(1'b0));
    $display("reset: busy=%b done=%b out=%h", bus.busy, bus.done, bus.aluout);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back single-cycle table; each start lands in the previous done cycle.
    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].instr, vecs[i].rd, vecs[i].rs);
      check_done($sformatf("vec%0d", i), vecs[i].out, vecs[i].wen, vecs[i].carry, vecs[i].skip);
    end

    // Squashed MUL completes in T+1 without entering the multiply.
    issue(mk(3'b100, 2'b00, 4'b0001, 1'b1), 16'h0003, 16'h0003);
    check_done("mul_squash", 16'h00FF, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("mul_squash.done_drop", 32'(bus.done), 32'(1'b0));

    // 0x0100 * 0x0100 = 0x10000; stray start and operand changes mid-run.
    issue(mk(3'b100, 2'b00, 4'b0010, 1'b1), 16'h0100, 16'h0100);
    lat = 1;
    gaps = 0;
    while (!bus.done && lat < 40) begin
      if (!bus.busy) gaps++;
      if (lat == 5) begin
        bus.instruction = mk(3'b000, 2'b00, 4'b0001, 1'b1);
        bus.rddata      = 16'hFFFF;
        bus.rsdata      = 16'h0001;
        bus.start       = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    check("mul256.latency", 32'(lat), 32'd17);
    check("mul256.busy_gaps", 32'(gaps), 32'd0);
    check_done("mul256", 16'h0000, 1'b1, 1'b1, 1'b1);

    // Start in the MUL done cycle is accepted and squashed by the new skip.
    issue(mk(3'b000, 2'b00, 4'b0001, 1'b1), 16'h0001, 16'h0001);
    check_done("after_mul", 16'h0000, 1'b0, 1'b1, 1'b0);

    // Reset at T+5 aborts a MUL; reset beats a simultaneous start.
    issue(mk(3'b100, 2'b00, 4'b0011, 1'b1), 16'h0003, 16'h0005);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("abort.busy_before", 32'(bus.busy), 32'(1'b1));
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort.busy", 32'(bus.busy), 32'(1'b0));
    check("abort.done", 32'(bus.done), 32'(1'b0));
    check("abort.aluout", 32'(bus.aluout), 32'h0);
    check("abort.wenout", 32'(bus.wenout), 32'(1'b0));
    check("abort.carry", 32'(bus.carrystatus), 32'(1'b0));
    check("abort.skip", 32'(bus.skipstatus), 32'(1'b0));
    $display("abort: busy=%b done=%b out=%h", bus.busy, bus.done, bus.aluout);
    @(negedge clk);
    bus.instruction = mk(3'b000, 2'b00, 4'b0001, 1'b1);
    bus.rddata      = 16'h0001;
    bus.rsdata      = 16'h0001;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("rst_prio.done", 32'(bus.done), 32'(1'b0));
    check("rst_prio.aluout", 32'(bus.aluout), 32'h0);
    $display("rst_prio: done=%b out=%h", bus.done, bus.aluout);
    @(negedge clk);
    reset_n = 1'b1;

    // First start after release: 3 * 5 = 15, any leftover done would shorten latency.
    issue(mk(3'b100, 2'b00, 4'b0011, 1'b1), 16'h0003, 16'h0005);
    bus.rddata = 16'hAAAA;
    bus.rsdata = 16'h5555;
    wait_done(lat, gaps);
    check("mul15.latency", 32'(lat), 32'd17);
    check("mul15.busy_gaps", 32'(gaps), 32'd0);
    check_done("mul15", 16'h000F, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("mul15.done_drop", 32'(bus.done), 32'(1'b0));
    check("mul15.wen_drop", 32'(bus.wenout), 32'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
